jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares one bank of NFF jkff flip-flops (common clk/rst) between NREQ requesters.
//  Each requester issues a command: op + flop index.
//  Round-robin arbitration picks one command, drives J/K of the addressed flop for
//  exactly one clock, then returns the flop's new Q to the winning requester.
//  Sits between requester logic and the jkff bank; owns every J/K input of the bank.
// PARAMETERS
//  NREQ  4  number of requesters
//  IDW   2  requester-id width; 2**IDW >= NREQ
//  NFF   6  number of jkff instances in the bank
//  IDXW  3  flop-index width; 2**IDXW >= NFF
// PORTS
//  clk        in   1          rising-edge clock, shared with the jkff bank
//  rst        in   1          async active-high reset, shared with the jkff bank
//  req_valid  in   NREQ       per-requester command valid
//  req_op     in   2*NREQ     op of requester i at [2i+1:2i]; 00 hold, 01 clear, 10 set, 11 toggle
//  req_idx    in   IDXW*NREQ  flop index of requester i at [IDXW*i +: IDXW]
//  req_ready  out  NREQ       one-hot grant; handshake = valid & ready
//  ff_j       out  NFF        J inputs of the bank
//  ff_k       out  NFF        K inputs of the bank
//  ff_q       in   NFF        Q outputs of the bank
//  rsp_valid  out  1          one-cycle response strobe
//  rsp_id     out  IDW        requester the response belongs to
//  rsp_q      out  1          Q of the addressed flop after the op
//  rsp_err    out  1          index >= NFF
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, any state):
//   - state = IDLE, RR pointer = 0.
//   - Outputs 0: ff_j, ff_k, req_ready, rsp_*, busy.
//   - Any in-flight command is dropped with no response.
//  FSM: IDLE -> DRIVE -> RESP -> IDLE. Exactly one command every 3 cycles; no pipelining.
//  IDLE:
//   - If any req_valid is high, the winner is the first valid requester at or after
//     pointer, wrapping at NREQ-1 -> 0.
//   - req_ready[winner] = 1 combinationally in this cycle; all other ready bits = 0.
//   - At the clock edge: latch winner id, op and idx; pointer = (winner+1) mod NREQ;
//     go to DRIVE.
//   - No valid: stay in IDLE; pointer unchanged.
//  DRIVE (1 cycle):
//   - Bit idx of ff_j/ff_k = {op[1],op[0]}; all other bits 0.
//   - The bank captures at the end of this cycle.
//   - If idx >= NFF, all J/K bits are 0 (treated as hold).
//  RESP (1 cycle):
//   - rsp_valid=1, rsp_id=latched id.
//   - rsp_q = ff_q[idx], or 0 if idx >= NFF.
//   - rsp_err = (idx >= NFF).
//   - Return to IDLE.
//  Outside DRIVE, ff_j = ff_k = 0, so the bank holds.
//  Outside RESP, rsp_* = 0.
//  req_ready is 0 in DRIVE and RESP.
//  Requesters hold valid/op/idx stable until the handshake. Dropping valid early is
//  legal; the command is not taken.
//  A winner whose valid stays high after its handshake is a new command; it competes
//  at its rotated (lowest) priority.
//  Latency: handshake in cycle T -> J/K driven in T+1 -> rsp_valid in T+2 ->
//  next grant possible in T+3.
// TESTING
//  1. Reset: rst asserted during DRIVE (req0 set idx1) -> all outputs 0 immediately;
//     no rsp_valid; ff_q[1]=0; next grant goes to req0.
//  2. Set: req0 set idx2 -> req_ready=0001 @T; ff_j=000100, ff_k=0 @T+1;
//     rsp_valid=1, rsp_id=0, rsp_q=1 @T+2.
//  3. Toggle: req1 toggle idx5 twice -> ff_j=ff_k=100000 in each DRIVE;
//     rsp_q=1 then 0; responses 3 cycles apart.
//  4. Clear: req2 set idx0, then clear idx0 -> rsp_q 1 then 0; clear drives ff_k=000001, ff_j=0.
//  5. Round-robin: all four requesters hold valid with hold ops ->
//     grant order 0,1,2,3,0,1; ready pulses every 3 cycles; ff_j/ff_k stay 0.
//  6. Bad index: req3 set idx7 (NFF=6) -> ff_j=ff_k=0 in DRIVE;
//     rsp_err=1, rsp_q=0, rsp_id=3; bank Q unchanged.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// ============================================================================
// jk_bank_arbiter : round-robin arbiter sharing one JK flip-flop bank among
//                   NREQ requesters (IDLE -> DRIVE -> RESP, one command / 3 clk)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int NFF  = 6,
  parameter int IDXW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFF-1:0]       ff_j,
  output logic [NFF-1:0]       ff_k,
  input  logic [NFF-1:0]       ff_q,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_q,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [IDXW-1:0] r_idx;
  logic            r_bad;
  logic [NFF-1:0]  r_ff_j;
  logic [NFF-1:0]  r_ff_k;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_err;
  logic            r_busy;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [1:0]      w_op;
  logic [IDXW-1:0] w_idx;
  logic [NFF-1:0]  w_hot;
  logic            w_q;

  // Lowest valid index overall, overridden by the lowest valid at/after the pointer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any = 1'b1;
        w_win = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) >= r_ptr)) begin
        w_win = IDW'(i);
      end
    end
  end

  always_comb begin
    w_op  = '0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_op  = req_op[2*i +: 2];
        w_idx = req_idx[IDXW*i +: IDXW];
      end
    end
  end

  // An out-of-range index matches no flop, so it drives nothing and reads 0.
  always_comb begin
    w_hot = '0;
    w_q   = 1'b0;
    for (int f = 0; f < NFF; f++) begin
      w_hot[f] = (w_idx == IDXW'(f));
      if (r_idx == IDXW'(f)) begin
        w_q = ff_q[f];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (r_state == S_IDLE) && !rst && w_any && (w_win == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_ff_j      <= '0;
      r_ff_k      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_win;
            r_idx   <= w_idx;
            r_bad   <= ~|w_hot;
            r_ptr   <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            r_ff_j  <= w_op[1] ? w_hot : '0;
            r_ff_k  <= w_op[0] ? w_hot : '0;
            r_busy  <= 1'b1;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_ff_j      <= '0;
          r_ff_k      <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_err   <= r_bad;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_id    <= '0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ff_j      = r_ff_j;
  assign ff_k      = r_ff_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  // The bank updates on the DRIVE->RESP edge, so Q is read live during RESP.
  assign rsp_q     = r_rsp_valid & w_q;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
// ============================================================================
// tb_jk_bank_arbiter : directed scenarios plus randomized traffic for
//                      jk_bank_arbiter, with a behavioural JK bank and model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_jk_bank_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NFF  = 6;
  localparam int IDXW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NFF-1:0]       ff_j;
  logic [NFF-1:0]       ff_k;
  logic [NFF-1:0]       ff_q;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_q;
  logic                 rsp_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Reference state: round-robin pointer and expected flop contents.
  int             m_ptr;
  logic [NFF-1:0] m_q;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .IDW(IDW), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx), .req_ready(req_ready),
    .ff_j(ff_j), .ff_k(ff_k), .ff_q(ff_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural JK flip-flop bank sharing clk/rst with the arbiter.
  logic [NFF-1:0] r_bank;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank <= '0;
    end else begin
      for (int f = 0; f < NFF; f++) begin
        case ({ff_j[f], ff_k[f]})
          2'b01:   r_bank[f] <= 1'b0;
          2'b10:   r_bank[f] <= 1'b1;
          2'b11:   r_bank[f] <= ~r_bank[f];
          default: r_bank[f] <= r_bank[f];
        endcase
      end
    end
  end
  assign ff_q = r_bank;

  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int n = 0; n < NREQ; n++) begin
      if (v[(m_ptr + n) % NREQ]) return (m_ptr + n) % NREQ;
    end
    return -1;
  endfunction

  function automatic void model_apply(input int idx, input int op);
    if (idx < NFF) begin
      case (op)
        1: m_q[idx] = 1'b0;
        2: m_q[idx] = 1'b1;
        3: m_q[idx] = ~m_q[idx];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [NFF-1:0] exp_drive(input int idx, input bit on);
    logic [NFF-1:0] v;
    v = '0;
    if (on && idx < NFF) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_q = '0;
  endtask

  // Issues one command from a lone requester and collects what the DUT shows
  // in the grant, drive and response cycles; also advances the model.
  task automatic do_cmd(input int r, input int op, input int idx,
                        output logic [NREQ-1:0] rdy, output logic [NFF-1:0] j,
                        output logic [NFF-1:0] k, output logic rv, output logic [IDW-1:0] id,
                        output logic q, output logic err, output time t);
    @(negedge clk);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = 2'(op);
    req_idx[IDXW*r +: IDXW] = IDXW'(idx);
    #1 rdy = req_ready;
    m_ptr = (r + 1) % NREQ;
    model_apply(idx, op);
    @(negedge clk);
    req_valid = '0;
    #1 j = ff_j;
    k = ff_k;
    @(negedge clk);
    #1 rv = rsp_valid;
    id = rsp_id;
    q = rsp_q;
    err = rsp_err;
    t = $time;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({ff_j, ff_k} !== '0) begin
      errors++; $display("FAIL reset_jk: got j=%b k=%b want 0", ff_j, ff_k);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_err, busy} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%0d q=%b e=%b busy=%b want all 0",
                         rsp_valid, rsp_id, rsp_q, rsp_err, busy);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_q = '0;
  endtask

  task automatic test_reset_in_drive();
    @(negedge clk);
    req_valid = 4'b0001;
    req_op[1:0] = 2'b10;
    req_idx[2:0] = 3'd1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rid_grant: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (ff_j !== 6'b000010 || busy !== 1'b1) begin
      errors++; $display("FAIL rid_drive: got j=%b busy=%b want 000010/1", ff_j, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ff_j, ff_k, req_ready, busy, rsp_valid} !== '0) begin
      errors++; $display("FAIL rid_async: got j=%b k=%b rdy=%b busy=%b rv=%b want 0",
                         ff_j, ff_k, req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_q = '0;
    #1;
    checks++;
    if (ff_q[1] !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rid_dropped: got q1=%b rv=%b want 0/0", ff_q[1], rsp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0011;
    req_op[3:0] = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rid_next_grant: got %b want 0001", req_ready);
    end
    m_ptr = 1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_set();
    logic [NREQ-1:0] rdy; logic [NFF-1:0] j, k; logic rv, q, err; logic [IDW-1:0] id; time t;
    do_cmd(0, 2, 2, rdy, j, k, rv, id, q, err, t);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL set_grant: got %b want 0001", rdy);
    end
    checks++;
    if (j !== 6'b000100 || k !== 6'b000000) begin
      errors++; $display("FAIL set_drive: got j=%b k=%b want 000100/000000", j, k);
    end
    checks++;
    if (rv !== 1'b1 || id !== 2'd0 || q !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL set_rsp: got v=%b id=%0d q=%b e=%b want 1/0/1/0", rv, id, q, err);
    end
  endtask

  task automatic test_toggle();
    logic [NREQ-1:0] rdy; logic [NFF-1:0] j, k; logic rv, q, err; logic [IDW-1:0] id;
    time t0, t1;
    for (int n = 0; n < 2; n++) begin
      do_cmd(1, 3, 5, rdy, j, k, rv, id, q, err, t1);
      checks++;
      if (j !== 6'b100000 || k !== 6'b100000) begin
        errors++; $display("FAIL toggle_drive%0d: got j=%b k=%b want 100000/100000", n, j, k);
      end
      checks++;
      if (rv !== 1'b1 || id !== 2'd1 || q !== (n == 0 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL toggle_rsp%0d: got v=%b id=%0d q=%b want 1/1/%0d",
                           n, rv, id, q, (n == 0) ? 1 : 0);
      end
      if (n == 1) begin
        checks++;
        if (t1 - t0 != 30) begin
          errors++; $display("FAIL toggle_spacing: got %0t want 30", t1 - t0);
        end
      end
      t0 = t1;
    end
  endtask

  task automatic test_clear();
    logic [NREQ-1:0] rdy; logic [NFF-1:0] j, k; logic rv, q, err; logic [IDW-1:0] id; time t;
    do_cmd(2, 2, 0, rdy, j, k, rv, id, q, err, t);
    checks++;
    if (q !== 1'b1 || id !== 2'd2) begin
      errors++; $display("FAIL clear_setfirst: got q=%b id=%0d want 1/2", q, id);
    end
    do_cmd(2, 1, 0, rdy, j, k, rv, id, q, err, t);
    checks++;
    if (j !== 6'b000000 || k !== 6'b000001) begin
      errors++; $display("FAIL clear_drive: got j=%b k=%b want 000000/000001", j, k);
    end
    checks++;
    if (rv !== 1'b1 || q !== 1'b0) begin
      errors++; $display("FAIL clear_rsp: got v=%b q=%b want 1/0", rv, q);
    end
  endtask

  task automatic test_round_robin();
    int w;
    pulse_reset();
    req_op = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      w = model_winner(req_valid);
      checks++;
      if (w != n % NREQ || req_ready !== NREQ'(1 << w)) begin
        errors++; $display("FAIL rr_grant%0d: got %b want onehot %0d", n, req_ready, n % NREQ);
      end
      m_ptr = (w + 1) % NREQ;
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== '0 || ff_j !== '0 || ff_k !== '0) begin
        errors++; $display("FAIL rr_drive%0d: got rdy=%b j=%b k=%b want 0", n, req_ready, ff_j, ff_k);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== IDW'(w)) begin
        errors++; $display("FAIL rr_rsp%0d: got rdy=%b v=%b id=%0d want 0/1/%0d",
                           n, req_ready, rsp_valid, rsp_id, w);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_bad_index();
    logic [NREQ-1:0] rdy; logic [NFF-1:0] j, k; logic rv, q, err; logic [IDW-1:0] id; time t;
    do_cmd(3, 2, 7, rdy, j, k, rv, id, q, err, t);
    checks++;
    if (rdy !== 4'b1000 || j !== '0 || k !== '0) begin
      errors++; $display("FAIL bad_drive: got rdy=%b j=%b k=%b want 1000/0/0", rdy, j, k);
    end
    checks++;
    if (rv !== 1'b1 || err !== 1'b1 || q !== 1'b0 || id !== 2'd3) begin
      errors++; $display("FAIL bad_rsp: got v=%b e=%b q=%b id=%0d want 1/1/0/3", rv, err, q, id);
    end
    checks++;
    if (ff_q !== m_q) begin
      errors++; $display("FAIL bad_bank: got %b want %b", ff_q, m_q);
    end
  endtask

  task automatic test_random();
    int w, op, idx;
    logic [NFF-1:0] ej, ek;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      req_valid = NREQ'($urandom_range(0, 15));
      req_op    = (2*NREQ)'($urandom);
      req_idx   = (IDXW*NREQ)'($urandom);
      #1;
      w = model_winner(req_valid);
      checks++;
      if (req_ready !== ((w < 0) ? NREQ'(0) : NREQ'(1 << w))) begin
        errors++; $display("FAIL rnd_grant%0d: got %b valid=%b ptr=%0d want winner %0d",
                           n, req_ready, req_valid, m_ptr, w);
      end
      if (w >= 0) begin
        op  = int'(req_op[2*w +: 2]);
        idx = int'(req_idx[IDXW*w +: IDXW]);
        ej  = exp_drive(idx, op[1]);
        ek  = exp_drive(idx, op[0]);
        m_ptr = (w + 1) % NREQ;
        model_apply(idx, op);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (ff_j !== ej || ff_k !== ek || busy !== 1'b1) begin
          errors++; $display("FAIL rnd_drive%0d: got j=%b k=%b busy=%b want %b/%b/1",
                             n, ff_j, ff_k, busy, ej, ek);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_err !== (idx >= NFF) ||
            rsp_q !== ((idx < NFF) ? m_q[idx] : 1'b0) || ff_q !== m_q) begin
          errors++; $display("FAIL rnd_rsp%0d: got v=%b id=%0d e=%b q=%b bank=%b want id=%0d idx=%0d bank=%b",
                             n, rsp_valid, rsp_id, rsp_err, rsp_q, ff_q, w, idx, m_q);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_idx = '0;
    m_ptr = 0;
    m_q = '0;
    test_reset();
    test_reset_in_drive();
    test_set();
    test_toggle();
    test_clear();
    test_round_robin();
    test_bad_index();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
